// File: rtl/conv_pkg.sv
// Shared types and width helper for the streaming convolution unit.
// Imported by the MAC tree and the stream controller.
package conv_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        BORDER_ZERO = 1'b0,
        BORDER_PASS = 1'b1
    } border_e;

    // Wide enough for K*K full-scale signed products without overflow.
    function automatic int acc_w(input int data_w, input int coef_w, input int k);
        return data_w + coef_w + $clog2(k * k) + 1;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Combinational K*K multiply-add tree: unsigned pixels times signed
// coefficients, summed into one signed accumulator.
module conv_mac
    import conv_pkg::*;
#(
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = acc_w(DATA_W, COEF_W, K)
) (
    input  logic [K*K*DATA_W-1:0]    win_i,
    input  logic [K*K*COEF_W-1:0]    coef_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [ACC_W-1:0] prod [K*K];

    genvar g;
    generate
        for (g = 0; g < K * K; g++) begin : g_mul
            logic signed [ACC_W-1:0] px;
            logic signed [ACC_W-1:0] cf;
            // Pixels are zero-extended; coefficients sign-extended.
            assign px = ACC_W'($signed({1'b0, win_i[g*DATA_W +: DATA_W]}));
            assign cf = ACC_W'($signed(coef_i[g*COEF_W +: COEF_W]));
            assign prod[g] = px * cf;
        end
    endgenerate

    always_comb begin
        acc_o = '0;
        for (int n = 0; n < K * K; n++) begin
            acc_o = acc_o + prod[n];
        end
    end

endmodule

// File: rtl/conv_stream_cu.sv
// Streaming KxK convolution controller: column window, frame counters,
// border handling and a registered valid/ready output stage.
module conv_stream_cu
    import conv_pkg::*;
#(
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [K*K*COEF_W-1:0]   fil_coe_i,
    input  logic                    fil_load_i,
    input  logic [4:0]              shift_i,
    input  logic                    border_mode_i,
    input  logic [K*DATA_W-1:0]     data_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [DATA_W-1:0]       data_o,
    output logic                    v_o,
    input  logic                    ready_i,
    output logic                    last_o,
    output logic                    busy_o
);

    localparam int H     = (K - 1) / 2;
    localparam int ACC_W = acc_w(DATA_W, COEF_W, K);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_W) - 1);

    state_e                     state_q, state_d;
    logic                       coef_valid_q;
    logic [K*K*COEF_W-1:0]      coef_q;
    logic [K*K*DATA_W-1:0]      win_q, win_d;
    logic [COL_W-1:0]           col_q;
    logic [ROW_W-1:0]           row_q;
    logic                       v_q, last_q;
    logic [DATA_W-1:0]          data_q;

    logic                       accept, frame_end, border;
    logic signed [ACC_W-1:0]    acc, acc_sh;
    logic [DATA_W-1:0]          pix_res, pix_out;
    logic [K*DATA_W-1:0]        unused_tail;

    assign accept    = v_i & ready_o;
    assign frame_end = accept
                     & (row_q == ROW_W'(IMG_H - 1))
                     & (col_q == COL_W'(IMG_W - 1));

    // win_d is the window including the column being accepted now.
    genvar gr, gj;
    generate
        for (gr = 0; gr < K; gr++) begin : g_row
            for (gj = 0; gj < K; gj++) begin : g_tap
                if (gj == 0) begin : g_new
                    assign win_d[(gr*K)*DATA_W +: DATA_W] =
                        data_i[gr*DATA_W +: DATA_W];
                end else begin : g_old
                    assign win_d[(gr*K+gj)*DATA_W +: DATA_W] =
                        win_q[(gr*K+gj-1)*DATA_W +: DATA_W];
                end
            end
            assign unused_tail[gr*DATA_W +: DATA_W] =
                win_q[(gr*K+K-1)*DATA_W +: DATA_W];
        end
    endgenerate

    conv_mac #(
        .K      (K),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .win_i  (win_d),
        .coef_i (coef_q),
        .acc_o  (acc)
    );

    assign acc_sh = acc >>> shift_i;

    always_comb begin
        pix_res = acc_sh[DATA_W-1:0];
        if (acc_sh[ACC_W-1]) begin
            pix_res = '0;
        end else if (acc_sh > PIX_MAX) begin
            pix_res = '1;
        end
    end

    assign border = (int'(col_q) < K - 1)
                  | (int'(row_q) < H)
                  | (int'(row_q) > IMG_H - 1 - H);

    always_comb begin
        pix_out = pix_res;
        if (border) begin
            pix_out = (border_e'(border_mode_i) == BORDER_PASS)
                    ? data_i[H*DATA_W +: DATA_W] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept && !frame_end) state_d = ST_RUN;
            ST_RUN:  if (frame_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q == ST_RUN);
        ready_o = (busy_o | coef_valid_q) & (!v_q | ready_i);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            coef_q       <= '0;
            coef_valid_q <= 1'b0;
        end else if (state_q == ST_IDLE && fil_load_i) begin
            coef_q       <= fil_coe_i;
            coef_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            win_q <= '0;
            col_q <= '0;
            row_q <= '0;
        end else if (frame_end) begin
            win_q <= '0;
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            win_q <= win_d;
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Accept only happens when the held result is free or being taken.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            v_q    <= 1'b1;
            data_q <= pix_out;
            last_q <= frame_end;
        end else if (ready_i) begin
            v_q    <= 1'b0;
            last_q <= 1'b0;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;
    assign last_o = last_q;

endmodule

// File: tb/tb_conv_stream_cu.sv
// Directed bench for conv_stream_cu on a 4x3 frame with a 3x3 kernel.
module tb_conv_stream_cu;

    localparam int K  = 3;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int IW = 4;
    localparam int IH = 3;

    localparam logic [K*K*CW-1:0] COEF_CENTER = {32'h0, 8'h01, 32'h0};
    localparam logic [K*K*CW-1:0] COEF_ONES   = {9{8'h01}};
    localparam logic [K*K*CW-1:0] COEF_NEG    = {9{8'hFF}};

    logic              clk = 1'b0;
    logic              reset_i;
    logic [K*K*CW-1:0] fil_coe;
    logic              fil_load;
    logic [4:0]        shift;
    logic              border_mode;
    logic [K*DW-1:0]   data_i;
    logic              v_i;
    logic              ready_o;
    logic [DW-1:0]     data_o;
    logic              v_o;
    logic              ready_i;
    logic              last_o;
    logic              busy_o;

    conv_stream_cu #(
        .K(K), .DATA_W(DW), .COEF_W(CW), .IMG_W(IW), .IMG_H(IH)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .fil_coe_i     (fil_coe),
        .fil_load_i    (fil_load),
        .shift_i       (shift),
        .border_mode_i (border_mode),
        .data_i        (data_i),
        .v_i           (v_i),
        .ready_o       (ready_o),
        .data_o        (data_o),
        .v_o           (v_o),
        .ready_i       (ready_i),
        .last_o        (last_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          exp_q[$];
    logic [7:0]  pix_tab[4];
    logic [7:0]  seq[12];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic observe();
        int e;
        if (v_o && ready_i) begin
            chk("out_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("data_o", 32'(data_o), e & 255);
                chk("last_o", 32'(last_o), e >> 8);
            end
        end
    endtask

    task automatic push_seq();
        for (int i = 0; i < IW * IH; i++) begin
            exp_q.push_back(int'(seq[i]) | ((i == IW * IH - 1) ? 256 : 0));
        end
    endtask

    task automatic load_coef(input logic [K*K*CW-1:0] c);
        fil_coe  = c;
        fil_load = 1'b1;
        @(negedge clk);
        fil_load = 1'b0;
    endtask

    task automatic run_frame(input int stall_at, input int load_at);
        logic acc;
        push_seq();
        for (int idx = 0; idx < IW * IH; idx++) begin
            v_i    = 1'b1;
            data_i = {3{pix_tab[idx % IW]}};
            if (idx == stall_at) begin
                ready_i = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    chk("stall_ready_o", 32'(ready_o), 0);
                    chk("stall_v_o", 32'(v_o), 1);
                    chk("stall_data_o", 32'(data_o), exp_q[0] & 255);
                    @(negedge clk);
                end
                ready_i = 1'b1;
            end
            if (idx == load_at) begin
                fil_coe  = COEF_ONES;
                fil_load = 1'b1;
            end
            acc = 1'b0;
            for (int t = 0; t < 4 && !acc; t++) begin
                #1;
                observe();
                if (idx > 0) chk("busy_o", 32'(busy_o), 1);
                acc = ready_o;
                @(negedge clk);
                fil_load = 1'b0;
            end
            chk("accepted", 32'(acc), 1);
        end
        v_i = 1'b0;
        for (int t = 0; t < 3; t++) begin
            #1;
            observe();
            @(negedge clk);
        end
        chk("drained", 32'(exp_q.size()), 0);
        #1 chk("idle_busy", 32'(busy_o), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i     = 1'b0;
        fil_coe     = '0;
        fil_load    = 1'b0;
        shift       = 5'd0;
        border_mode = 1'b0;
        data_i      = '0;
        v_i         = 1'b1;
        ready_i     = 1'b1;
        #2;
        chk("rst_v_o", 32'(v_o), 0);
        chk("rst_data_o", 32'(data_o), 0);
        chk("rst_last_o", 32'(last_o), 0);
        chk("rst_busy_o", 32'(busy_o), 0);
        chk("rst_ready_o", 32'(ready_o), 0);
        @(negedge clk);
        reset_i = 1'b1;
        #1 chk("nocoef_ready_o", 32'(ready_o), 0);
        v_i = 1'b0;
        @(negedge clk);

        load_coef(COEF_CENTER);
        #1;
        chk("loaded_ready_o", 32'(ready_o), 1);
        chk("loaded_busy_o", 32'(busy_o), 0);
        @(negedge clk);

        // Centre tap only; a load pulsed mid-frame must be ignored.
        pix_tab = '{8'd10, 8'd20, 8'd30, 8'd40};
        seq = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                8'd20, 8'd30, 8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(-1, 5);
        run_frame(7, -1);

        load_coef(COEF_ONES);
        shift   = 5'd3;
        pix_tab = '{8'd255, 8'd255, 8'd255, 8'd255};
        seq = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(-1, -1);

        load_coef(COEF_NEG);
        shift   = 5'd0;
        pix_tab = '{8'd100, 8'd100, 8'd100, 8'd100};
        seq = '{default: 8'd0};
        run_frame(-1, -1);
        border_mode = 1'b1;
        seq = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100,
                8'd0, 8'd0, 8'd100, 8'd100, 8'd100, 8'd100};
        run_frame(-1, -1);

        // Mid-frame asynchronous reset.
        border_mode = 1'b0;
        load_coef(COEF_CENTER);
        pix_tab = '{8'd10, 8'd20, 8'd30, 8'd40};
        for (int idx = 0; idx < 7; idx++) begin
            v_i    = 1'b1;
            data_i = {3{pix_tab[idx % IW]}};
            #1 chk("pre_rst_ready_o", 32'(ready_o), 1);
            @(negedge clk);
        end
        #1;
        chk("pre_rst_data_o", 32'(data_o), 20);
        chk("pre_rst_v_o", 32'(v_o), 1);
        chk("pre_rst_busy_o", 32'(busy_o), 1);
        #2 reset_i = 1'b0;
        #1;
        chk("arst_v_o", 32'(v_o), 0);
        chk("arst_data_o", 32'(data_o), 0);
        chk("arst_last_o", 32'(last_o), 0);
        chk("arst_busy_o", 32'(busy_o), 0);
        chk("arst_ready_o", 32'(ready_o), 0);
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b1;
        for (int t = 0; t < 3; t++) begin
            #1;
            chk("post_rst_ready_o", 32'(ready_o), 0);
            chk("post_rst_v_o", 32'(v_o), 0);
            @(negedge clk);
        end
        v_i = 1'b0;
        exp_q.delete();
        load_coef(COEF_CENTER);
        seq = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
                8'd20, 8'd30, 8'd0, 8'd0, 8'd0, 8'd0};
        run_frame(-1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
